sv_host: RTL
============

SV_HOST -- requirements
Module: sv_host

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32, meaning bus address width.
REQ-002 SHALL have parameter DATA_SIZE, default 32, meaning bus data width; only 32 is supported.
REQ-003 SHALL have parameter BLOCK_SIZE, default 256, meaning operand/result width in bits.
REQ-004 SHALL have parameter TIMEOUT, default 100000, meaning maximum cycles to wait for completion IRQ.
REQ-005 SHALL have the port list below; one clock; reset is asynchronous and active-low.
- clk  input  1  clock, all logic on rising edge.
- areset  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  command request.
- cmd_ready_o  output  1  command accepted when high together with cmd_valid_i.
- cmd_op_i  input  2  opcode: 0 WRITE_BLOCK, 1 READ_BLOCK, 2 SET_START, 3 RUN.
- cmd_bank_i  input  3  target bank.
- cmd_data_i  input  BLOCK_SIZE  write block; [7:0] is the start address for SET_START.
- rsp_valid_o  output  1  one-cycle completion pulse.
- rsp_err_o  output  1  error flag, valid with rsp_valid_o.
- rsp_data_o  output  BLOCK_SIZE  read block, valid with rsp_valid_o for READ_BLOCK.
- a_o  output  ADDR_SIZE  core bus address.
- c_o  output  1  core bus access strobe.
- w_o  output  1  write (1) / read (0).
- s_o  output  3  access size; always 2 (32-bit).
- d_o  output  DATA_SIZE  write data.
- d_i  input  DATA_SIZE  read data, registered by core, valid one cycle after the read strobe.
- core_ready_i  input  1  core idle and able to take accesses.
- irq_i  input  1  core completion pulse.

Function
REQ-006 SHALL implement states IDLE, WRITE, READ, SET, RUN, WAIT_IRQ, RESP.
REQ-007 SHALL drive cmd_ready_o high only in IDLE; accept the command on cmd_valid_i & cmd_ready_o and latch op, bank and data.
REQ-008 SHALL map WRITE_BLOCK to 8 word writes: a_o = {bank, 8'(4*k)}, d_o = cmd_data_i[32k+31:32k], k = 0..7 ascending.
REQ-009 SHALL reject WRITE_BLOCK with bank 0 or 7 by going directly to RESP with rsp_err_o=1 and issuing no bus access.
REQ-010 SHALL map READ_BLOCK (any bank 0..7) to 8 word reads at a_o = {bank, 8'(4*k)}, capturing d_i into rsp_data_o[32k+31:32k] on the cycle after each strobe.
REQ-011 SHALL pipeline reads: a new read may issue in the same cycle as the previous capture; 8 reads with no stall complete in 9 cycles.
REQ-012 SHALL map SET_START to one write at a_o = 0x80 with d_o = {24'b0, cmd_data_i[7:0]}.
REQ-013 SHALL map RUN to one write at a_o = 0x00, d_o = 0, then enter WAIT_IRQ.
REQ-014 SHALL assert c_o only when core_ready_i is high; when core_ready_i is low, hold the word index and retry; no access is lost or duplicated.
REQ-015 SHALL in WAIT_IRQ count cycles from 0; irq_i=1 -> RESP with rsp_err_o=0; count reaching TIMEOUT-1 without irq_i -> RESP with rsp_err_o=1.
REQ-016 SHALL ignore irq_i outside WAIT_IRQ.
REQ-017 SHALL in RESP pulse rsp_valid_o for exactly one cycle, then return to IDLE.
REQ-018 SHALL hold rsp_data_o stable until the next READ_BLOCK capture begins.
REQ-019 SHALL drive w_o=0, d_o=0 and a_o=0 whenever c_o=0.

Reset
REQ-020 SHALL on areset low, immediately and mid-operation, go to IDLE with the following outputs: c_o=0, w_o=0, a_o=0, d_o=0, s_o=2, rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0, cmd_ready_o=1 after release, word index and timeout counter cleared.

Verification
REQ-021 WRITE_BLOCK bank 3, data words 0x03020100..0x1F1E1D1C, core_ready_i=1 -> 8 consecutive writes at a_o 0x300..0x31C with matching d_o, then one rsp_valid_o with rsp_err_o=0.
REQ-022 READ_BLOCK bank 0, core model returns 0xA0000000+k -> rsp_data_o word k = 0xA0000000+k, and rsp_valid_o asserts 10 cycles after acceptance.
REQ-023 RUN, core drops core_ready_i and pulses irq_i after 50 cycles -> exactly one write at a_o=0x000, then rsp_valid_o with rsp_err_o=0; TIMEOUT=20 with no irq_i -> rsp_err_o=1 after 20 wait cycles.
REQ-024 WRITE_BLOCK with core_ready_i low for 3 cycles at k=4 -> c_o=0 for 3 cycles, then k=4..7 issued once each, 8 total writes.
REQ-025 WRITE_BLOCK bank 7 -> no c_o, rsp_valid_o with rsp_err_o=1; SET_START data 0x5A -> write a_o=0x80, d_o=0x5A.
REQ-026 areset pulsed during READ at k=5 -> c_o=0 and rsp_valid_o=0 immediately, cmd_ready_o=1 after release, no stale response.

Source files
------------

// File: rtl/sv_host.sv
// Host-side command sequencer: turns block/start/run commands into 32-bit core
// bus accesses and waits for the core's completion interrupt.
//
// state    | meaning
// IDLE     | ready for a command
// WRITE    | issuing 8 word writes of the latched block
// READ     | issuing 8 pipelined word reads, capturing d_i one cycle later
// SET      | single write of the start address to 0x80
// RUN      | single write to 0x00 to kick the core
// WAIT_IRQ | counting cycles until irq_i or timeout
// RESP     | one-cycle response pulse
module sv_host #(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_SIZE  = 32,
    parameter int BLOCK_SIZE = 256,
    parameter int TIMEOUT    = 100000
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [2:0]            cmd_bank_i,
    input  logic [BLOCK_SIZE-1:0] cmd_data_i,
    output logic                  rsp_valid_o,
    output logic                  rsp_err_o,
    output logic [BLOCK_SIZE-1:0] rsp_data_o,
    output logic [ADDR_SIZE-1:0]  a_o,
    output logic                  c_o,
    output logic                  w_o,
    output logic [2:0]            s_o,
    output logic [DATA_SIZE-1:0]  d_o,
    input  logic [DATA_SIZE-1:0]  d_i,
    input  logic                  core_ready_i,
    input  logic                  irq_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_SET,
        S_RUN,
        S_WAIT_IRQ,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    state_t                  state;
    state_t                  state_next;
    logic [2:0]              bank_q;
    logic [BLOCK_SIZE-1:0]   data_q;
    logic [3:0]              idx;
    logic                    rd_pend;
    logic [2:0]              cap_idx;
    logic [31:0]             cnt;
    logic                    err_q;
    logic                    err_next;
    logic [BLOCK_SIZE-1:0]   rsp_data_q;
    logic                    accept;
    logic [31:0]             wr_word;

    assign accept      = cmd_valid_i && (state == S_IDLE);
    assign cmd_ready_o = (state == S_IDLE);
    assign rsp_valid_o = (state == S_RESP);
    assign rsp_err_o   = (state == S_RESP) && err_q;
    assign rsp_data_o  = rsp_data_q;
    assign s_o         = 3'd2;
    assign wr_word     = data_q[32*idx[2:0] +: 32];

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        c_o        = 1'b0;
        w_o        = 1'b0;
        a_o        = '0;
        d_o        = '0;
        case (state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    case (cmd_op_i)
                        OP_WRITE: begin
                            // Banks 0 and 7 are not writable; answer with an error, no bus traffic.
                            if (cmd_bank_i == 3'd0 || cmd_bank_i == 3'd7) begin
                                state_next = S_RESP;
                                err_next   = 1'b1;
                            end else begin
                                state_next = S_WRITE;
                            end
                        end
                        OP_READ:  state_next = S_READ;
                        OP_SET:   state_next = S_SET;
                        default:  state_next = S_RUN;
                    endcase
                end
            end
            S_WRITE: begin
                if (core_ready_i) begin
                    c_o = 1'b1;
                    w_o = 1'b1;
                    a_o = ADDR_SIZE'({bank_q, 3'b000, idx[2:0], 2'b00});
                    d_o = DATA_SIZE'(wr_word);
                    if (idx == 4'd7) begin
                        state_next = S_RESP;
                    end
                end
            end
            S_READ: begin
                if (idx < 4'd8) begin
                    if (core_ready_i) begin
                        c_o = 1'b1;
                        a_o = ADDR_SIZE'({bank_q, 3'b000, idx[2:0], 2'b00});
                    end
                end else if (rd_pend) begin
                    // Last word lands this cycle.
                    state_next = S_RESP;
                end
            end
            S_SET: begin
                if (core_ready_i) begin
                    c_o        = 1'b1;
                    w_o        = 1'b1;
                    a_o        = ADDR_SIZE'(8'h80);
                    d_o        = DATA_SIZE'({24'b0, data_q[7:0]});
                    state_next = S_RESP;
                end
            end
            S_RUN: begin
                if (core_ready_i) begin
                    c_o        = 1'b1;
                    w_o        = 1'b1;
                    state_next = S_WAIT_IRQ;
                end
            end
            S_WAIT_IRQ: begin
                if (irq_i) begin
                    state_next = S_RESP;
                end else if (cnt == 32'(TIMEOUT - 1)) begin
                    state_next = S_RESP;
                    err_next   = 1'b1;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            bank_q     <= '0;
            data_q     <= '0;
            idx        <= '0;
            rd_pend    <= 1'b0;
            cap_idx    <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                bank_q  <= cmd_bank_i;
                data_q  <= cmd_data_i;
                idx     <= '0;
                cnt     <= '0;
                rd_pend <= 1'b0;
            end
            if (c_o && (state == S_WRITE || state == S_READ)) begin
                idx <= idx + 4'd1;
            end
            if (state == S_READ) begin
                rd_pend <= c_o;
                if (c_o) begin
                    cap_idx <= idx[2:0];
                end
                if (rd_pend) begin
                    rsp_data_q[32*cap_idx +: 32] <= d_i[31:0];
                end
            end
            if (state == S_WAIT_IRQ && state_next == S_WAIT_IRQ) begin
                cnt <= cnt + 32'd1;
            end
            if (state_next == S_RESP && state != S_RESP) begin
                err_q <= err_next;
            end
        end
    end

endmodule
